// File: rtl/hazard_pkg.sv
// hazard_pkg: constants shared by the hazard scoreboard and its countdown cells.
//   REG_W   - register-number width
//   NREGS   - architectural register count (register 0 is hard-wired zero)
//   CNT_W   - width of every availability countdown
//   LAT_ALU - load value for a plain ALU result (covered by EX/MEM forwarding)
package hazard_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned NREGS   = 32;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned LAT_ALU = 0;

endpackage

// File: rtl/sb_counter.sv
// sb_counter: one availability countdown. Loads on load_i, otherwise counts down to zero
// and holds there. A load wins over the decrement in the same cycle.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-high reset, clears the count
//   load_i     - load load_val_i this cycle
//   load_val_i - value to load
//   cnt_o      - current count
//   zero_o     - count is zero (resource available)
module sb_counter
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decides whether the instruction in ID may issue. Each register has a
// countdown of cycles until its pending result reaches a forwarding path; the multiplier
// has its own busy countdown. Stall outputs are combinational from state and ID inputs.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   id_valid                 - ID holds a real instruction
//   id_rs, id_rt             - source registers; id_uses_rs/id_uses_rt say they are read
//   id_rd, id_regwrite       - destination register and its write enable
//   id_memread, id_mult      - instruction is a load / uses the multiplier
//   id_flush                 - ID instruction squashed (taken branch)
//   stall                    - hold PC and IF/ID, bubble ID/EX
//   pc_write, ifid_write     - ~stall
//   idex_bubble              - stall | id_flush
//   stall_count              - saturating count of stall cycles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_mult,
    input  logic             id_flush,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic [15:0]      stall_count
);

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] LoadLoad = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] AluLoad  = CNT_W'(LAT_ALU);
    localparam logic [CNT_W-1:0] MaxCnt   = (MultLoad > LoadLoad) ? MultLoad : LoadLoad;

    logic [NREGS-1:0] reg_busy;
    logic [CNT_W-1:0] reg_cnt [NREGS];
    logic [CNT_W-1:0] mult_cnt;
    logic             mult_zero;
    logic [CNT_W-1:0] wr_val;
    logic             wr_issue;
    logic             issue;
    logic             hazard;
    logic [15:0]      stall_cnt_q;
    logic [15:0]      stall_cnt_d;

    // Multiply wins over load when both flags are set.
    always_comb begin
        if (id_mult) begin
            wr_val = MultLoad;
        end else if (id_memread) begin
            wr_val = LoadLoad;
        end else begin
            wr_val = AluLoad;
        end
    end

    assign wr_issue = issue & id_regwrite & (id_rd != '0);

    // Register 0 is never tracked.
    assign reg_busy[0] = 1'b0;
    assign reg_cnt[0]  = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        logic zero;

        sb_counter u_cnt (
            .clk_i      (clk),
            .rst_i      (rst),
            .load_i     (wr_issue && (id_rd == REG_W'(r))),
            .load_val_i (wr_val),
            .cnt_o      (reg_cnt[r]),
            .zero_o     (zero)
        );

        assign reg_busy[r] = ~zero;

        a_cnt_range: assert property (@(posedge clk) disable iff (rst) reg_cnt[r] <= MaxCnt);
    end

    sb_counter u_mult (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (issue & id_mult),
        .load_val_i (MultLoad),
        .cnt_o      (mult_cnt),
        .zero_o     (mult_zero)
    );

    a_mult_range: assert property (@(posedge clk) disable iff (rst) mult_cnt <= MultLoad);

    // reg_busy[0] is 0, so the WAW term needs no explicit id_rd != 0 check.
    assign hazard = (id_uses_rs & reg_busy[id_rs])
                  | (id_uses_rt & reg_busy[id_rt])
                  | (id_regwrite & reg_busy[id_rd])
                  | (id_mult & ~mult_zero);

    // Flush masks the stall: a squashed instruction never waits.
    assign stall       = id_valid & ~id_flush & hazard;
    assign issue       = id_valid & ~id_flush & ~stall;
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign idex_bubble = stall | id_flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the driver computes expected outputs from a timestamp model (each
// register records the cycle its value becomes forwardable) and queues them; a monitor
// pops and compares every cycle. A second instance runs a long stall stream for saturation.
module tb_hazard_scoreboard;

    localparam int MULT_LAT = 4;
    localparam int LOAD_LAT = 1;

    typedef struct {
        logic        stall;
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic [15:0] cnt;
        logic [2:0]  c5;
        logic [2:0]  mc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0, id_mult = 1'b0, id_flush = 1'b0;
    logic        stall, pc_write, ifid_write, idex_bubble;
    logic [15:0] stall_count;

    logic        s_rst = 1'b1;
    logic        s_stall, s_pc_write, s_ifid_write, s_idex_bubble;
    logic [15:0] s_stall_count;

    int total = 0;
    int bad   = 0;

    exp_t expq[$];
    int   ready_at[32];
    int   mult_free = 0;
    int   tc = 0;
    int   scnt = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MULT_LAT(MULT_LAT), .LOAD_LAT(LOAD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_mult     (id_mult),
        .id_flush    (id_flush),
        .stall       (stall),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .idex_bubble (idex_bubble),
        .stall_count (stall_count)
    );

    // Saturation instance: "lw r5,0(r5)" held in ID forever, 7 stalls per 8 cycles.
    hazard_scoreboard #(.MULT_LAT(7), .LOAD_LAT(7)) dut_sat (
        .clk         (clk),
        .rst         (s_rst),
        .id_valid    (1'b1),
        .id_rs       (5'd5),
        .id_rt       (5'd0),
        .id_uses_rs  (1'b1),
        .id_uses_rt  (1'b0),
        .id_rd       (5'd5),
        .id_regwrite (1'b1),
        .id_memread  (1'b1),
        .id_mult     (1'b0),
        .id_flush    (1'b0),
        .stall       (s_stall),
        .pc_write    (s_pc_write),
        .ifid_write  (s_ifid_write),
        .idex_bubble (s_idex_bubble),
        .stall_count (s_stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit busy(input int r);
        return (r != 0) && (tc < ready_at[r]);
    endfunction

    function automatic int rem(input int at);
        return (at > tc) ? at - tc : 0;
    endfunction

    // One cycle: drive ID at the falling edge, queue the expected outputs, advance the model.
    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input int rd, input logic rw, input logic mr,
                         input logic mu, input logic fl, input logic r, output logic iss);
        logic hz;
        logic st;
        int   lat;
        exp_t e;
        @(negedge clk);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
        id_rd = 5'(rd); id_regwrite = rw; id_memread = mr; id_mult = mu; id_flush = fl;
        rst = r;
        hz = (urs && busy(rs)) || (urt && busy(rt)) || (rw && busy(rd))
             || (mu && (tc < mult_free));
        st  = v && !fl && hz;
        iss = v && !fl && !st;
        e.stall = st; e.pcw = !st; e.ifw = !st; e.bub = st || fl;
        e.cnt = 16'(scnt); e.c5 = 3'(rem(ready_at[5])); e.mc = 3'(rem(mult_free));
        expq.push_back(e);
        if (r) begin
            foreach (ready_at[i]) ready_at[i] = 0;
            mult_free = 0;
            scnt = 0;
        end else begin
            if (st && scnt < 65535) scnt++;
            if (iss && rw && rd != 0) begin
                lat = mu ? MULT_LAT - 1 : (mr ? LOAD_LAT : 0);
                ready_at[rd] = tc + 1 + lat;
            end
            if (iss && mu) mult_free = tc + MULT_LAT;
        end
        tc++;
    endtask

    task automatic idle();
        logic iss;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, iss);
    endtask

    // Hold one instruction in ID until it issues (or is flushed); count DUT stall cycles.
    task automatic run_instr(input string name, input int rs, input int rt, input logic urs,
                             input logic urt, input int rd, input logic rw, input logic mr,
                             input logic mu, input logic fl, input int exp_st);
        int   st = 0;
        int   n = 0;
        logic iss;
        do begin
            drive(1'b1, rs, rt, urs, urt, rd, rw, mr, mu, fl, 1'b0, iss);
            #2;
            if (stall === 1'b1) st++;
            n++;
        end while (!iss && !fl && n < 20);
        chk({name, " stall cycles"}, st, exp_st);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall", stall, e.stall);
                chk("pc_write", pc_write, e.pcw);
                chk("ifid_write", ifid_write, e.ifw);
                chk("idex_bubble", idex_bubble, e.bub);
                chk("stall_count", stall_count, e.cnt);
                chk("cnt_r5", dut.reg_cnt[5], e.c5);
                chk("mult_cnt", dut.mult_cnt, e.mc);
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic main_seq();
        logic iss;
        idle();
        idle();
        // lw r5 ; add r6,r5,r1
        run_instr("lw r5", 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_instr("add r6,r5,r1", 5, 1, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        #2 chk("stall_count after load-use", stall_count, 1);
        // add r3 ; sub r4,r3,r2
        run_instr("add r3", 1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_instr("sub r4,r3,r2", 3, 2, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        // mult r7 ; mult r8 ; add r9,r7,r0
        run_instr("mult r7", 1, 2, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_instr("mult r8", 1, 2, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b1, 1'b0, 3);
        run_instr("add r9,r7,r0", 7, 0, 1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle();
        idle();
        idle();
        // lw r5 ; flushed writer of r5
        run_instr("lw r5 again", 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_instr("flushed r5 writer", 5, 0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        // lw r0 ; add r1,r0,r0
        run_instr("lw r0", 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_instr("add r1,r0,r0", 0, 0, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        // Reset in the middle of a multiplier stall
        run_instr("mult r7 pre-reset", 1, 2, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        drive(1'b1, 1, 2, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, iss);
        drive(1'b1, 1, 2, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, iss);
        run_instr("mult r8 post-reset", 1, 2, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            drive(logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 7) == 0),
                  logic'($urandom_range(0, 127) == 0), iss);
        end
        idle();
    endtask

    task automatic sat_seq();
        @(negedge clk);
        s_rst = 1'b0;
        // Cycles 0..799: issues at 0,8,...,792 -> 800 - 100 stalls.
        repeat (800) @(negedge clk);
        #2 chk("sat stall_count after 800 cycles", s_stall_count, 700);
        repeat (79200) @(negedge clk);
        #2;
        chk("sat stall_count saturated", s_stall_count, 16'hFFFF);
        chk("sat stall on issue cycle", s_stall, 1'b0);
        @(negedge clk);
        #2;
        chk("sat stall_count holds", s_stall_count, 16'hFFFF);
        chk("sat stall", s_stall, 1'b1);
    endtask

    initial begin : stim
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        fork
            main_seq();
            sat_seq();
        join
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #5;
        chk("scoreboard drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter: MULT_LAT, default 4, EX-to-forwardable latency of the multi-cycle multiplier (legal 2..7).
REQ-002 SHALL have parameter: LOAD_LAT, default 1, extra cycles before a load result is forwardable (legal 1..7).
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port: id_valid  in  1  ID stage holds a real instruction.
REQ-006 SHALL have port: id_rs, id_rt  in  5 each  source register numbers.
REQ-007 SHALL have port: id_uses_rs, id_uses_rt  in  1 each  the source is actually read.
REQ-008 SHALL have port: id_rd  in  5  destination register number.
REQ-009 SHALL have port: id_regwrite  in  1  the instruction writes id_rd.
REQ-010 SHALL have port: id_memread  in  1  the instruction is a load.
REQ-011 SHALL have port: id_mult  in  1  the instruction uses the multiplier.
REQ-012 SHALL have port: id_flush  in  1  the ID instruction is squashed (taken branch).
REQ-013 SHALL have port: stall  out  1  hold PC and IF/ID, insert a bubble into ID/EX.
REQ-014 SHALL have port: pc_write, ifid_write  out  1 each  equal ~stall.
REQ-015 SHALL have port: idex_bubble  out  1  zero control fields of ID/EX; equals stall | id_flush.
REQ-016 SHALL have port: stall_count  out  16  saturating count of stall cycles.

Function
REQ-017 SHALL hold one 3-bit countdown cnt[r] per register r=1..31; cnt[r]=0 means r is available via the forwarding paths or the register file; register 0 is never tracked and always reads as 0.
REQ-018 SHALL define issue = id_valid & ~id_flush & ~stall.
REQ-019 SHALL assert stall combinationally when id_valid & ~id_flush and any holds: RAW on rs (id_uses_rs & cnt[id_rs]!=0); RAW on rt (id_uses_rt & cnt[id_rt]!=0); WAW (id_regwrite & id_rd!=0 & cnt[id_rd]!=0); structural (id_mult & mult_cnt!=0).
REQ-020 SHALL, on a clock edge with issue & id_regwrite & id_rd!=0, load cnt[id_rd] with LOAD_LAT if id_memread, MULT_LAT-1 if id_mult, else 0 (plain ALU result, covered by EX/MEM forwarding).
REQ-021 SHALL decrement every nonzero cnt[r] by 1 per cycle, stalled or not; cnt SHALL never wrap below 0.
REQ-022 SHALL take the issue load for id_rd over the decrement when both apply in the same cycle.
REQ-023 SHALL keep a 3-bit mult_cnt, loaded with MULT_LAT-1 on issue & id_mult and decremented toward 0 each cycle; this tracks the multiplier being busy.
REQ-024 SHALL treat id_memread & id_mult together as a mult (mult takes precedence).
REQ-025 SHALL give id_flush priority over stall: when id_flush=1, stall=0, nothing issues, and idex_bubble=1.
REQ-026 SHALL increment stall_count on each cycle with stall=1 and saturate at 16'hFFFF.
REQ-027 SHALL be a pure function of state and current inputs for stall, pc_write, ifid_write and idex_bubble (no output register).

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear all cnt[r], mult_cnt and stall_count to 0, overriding any issue in that cycle.
REQ-029 SHALL, with state at reset values, drive stall=0, pc_write=1, ifid_write=1, idex_bubble=id_flush and stall_count=0.

Structure
REQ-030 SHALL place constants in a shared package hazard_pkg: REG_W=5, NREGS=32, CNT_W=3, LAT_ALU=0.
REQ-031 SHALL factor the per-register countdown (load, decrement, zero flag) into a single sub-module sb_counter, instantiated 31 times plus once for mult_cnt.
REQ-032 SHALL not modify or duplicate the forwarding-select logic, which remains a separate block.

Verification
REQ-033 SHALL cover: lw r5 issued, then add r6,r5,r1 next cycle -> stall=1 for exactly 1 cycle (LOAD_LAT=1), then the add issues; stall_count=1.
REQ-034 SHALL cover: add r3 issued, then sub r4,r3,r2 next cycle -> stall stays 0 (forwarding covers it).
REQ-035 SHALL cover: mult r7 issued, then mult r8 next -> stall=1 for 3 cycles with MULT_LAT=4; a following add r9,r7,r0 -> no stall after that.
REQ-036 SHALL cover: lw r5, then an instruction writing r5 with id_flush=1 in the same cycle -> stall=0, idex_bubble=1, cnt[5] unchanged.
REQ-037 SHALL cover: lw r0, then add r1,r0,r0 -> no stall (register 0 is never tracked).
REQ-038 SHALL cover: rst asserted during a mult stall -> next cycle stall=0, stall_count=0, mult_cnt=0; then 70000 forced stall cycles -> stall_count=16'hFFFF.
